// File: rtl/fir_stream_framer.sv
// Streaming FIR filter with half-up rounding, saturation and FFT frame marking.
// Pipeline: delay line -> registered MAC -> registered round/saturate output.
module fir_stream_framer #(
  parameter int unsigned TAPS  = 32,
  parameter int unsigned DW    = 16,
  parameter int unsigned CW    = 20,
  parameter int unsigned FRAME = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 data_valid,
  input  logic signed [DW-1:0] data,
  input  logic                 flush,
  input  logic                 coef_we,
  input  logic [5:0]           coef_addr,
  input  logic signed [CW-1:0] coef_wdata,
  output logic                 fir_valid,
  output logic signed [DW-1:0] fir_d,
  output logic                 fir_last,
  output logic                 busy
);

  localparam int unsigned AW   = DW + CW + $clog2(TAPS);
  localparam int unsigned WW   = $clog2(TAPS);
  localparam int unsigned FW   = $clog2(FRAME);
  localparam int unsigned FRAC = 16;

  localparam logic signed [AW-1:0] SAT_MAX = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_MIN = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  logic signed [DW-1:0] dly_q  [TAPS];
  logic signed [CW-1:0] coef_q [TAPS];

  logic                 pend_we_q;
  logic [5:0]           pend_addr_q;
  logic signed [CW-1:0] pend_data_q;

  logic [WW-1:0]        warm_q;
  logic [FW-1:0]        frame_q;
  logic                 s0_q;
  logic                 v1_q;
  logic signed [AW-1:0] acc_q;

  logic                 accept_c;
  logic                 warm_done_c;
  logic                 s0_c;
  logic signed [AW-1:0] acc_c;
  logic signed [AW-1:0] rnd_c;
  logic signed [AW-1:0] shf_c;
  logic signed [DW-1:0] sat_c;

  assign accept_c    = data_valid & ~flush;
  assign warm_done_c = (warm_q == WW'(TAPS - 1));
  assign s0_c        = accept_c & warm_done_c;

  // Writes land one edge late so the MAC for a same-cycle sample still sees the old value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_we_q   <= 1'b0;
      pend_addr_q <= '0;
      pend_data_q <= '0;
      for (int k = 0; k < TAPS; k++) begin
        coef_q[k] <= (k == 0) ? CW'(32'sd65536) : '0;
      end
    end else begin
      pend_we_q   <= coef_we && (32'(coef_addr) < TAPS);
      pend_addr_q <= coef_addr;
      pend_data_q <= coef_wdata;
      for (int k = 0; k < TAPS; k++) begin
        if (pend_we_q && (pend_addr_q == 6'(k))) coef_q[k] <= pend_data_q;
      end
    end
  end

  // Exact full-width dot product over the delay line.
  always_comb begin
    acc_c = '0;
    for (int k = 0; k < TAPS; k++) begin
      acc_c = acc_c + AW'(dly_q[k]) * AW'(coef_q[k]);
    end
  end

  // Round half-up, drop the fraction, clamp to the output range.
  always_comb begin
    rnd_c = acc_q + AW'(32'sd32768);
    shf_c = rnd_c >>> FRAC;
    if (shf_c > SAT_MAX) begin
      sat_c = {1'b0, {(DW-1){1'b1}}};
    end else if (shf_c < SAT_MIN) begin
      sat_c = {1'b1, {(DW-1){1'b0}}};
    end else begin
      sat_c = shf_c[DW-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < TAPS; k++) dly_q[k] <= '0;
      warm_q    <= '0;
      frame_q   <= '0;
      s0_q      <= 1'b0;
      v1_q      <= 1'b0;
      acc_q     <= '0;
      fir_valid <= 1'b0;
      fir_last  <= 1'b0;
      fir_d     <= '0;
      busy      <= 1'b0;
    end else if (flush) begin
      for (int k = 0; k < TAPS; k++) dly_q[k] <= '0;
      warm_q    <= '0;
      frame_q   <= '0;
      s0_q      <= 1'b0;
      v1_q      <= 1'b0;
      fir_valid <= 1'b0;
      fir_last  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      if (accept_c) begin
        dly_q[0] <= data;
        for (int k = 1; k < TAPS; k++) dly_q[k] <= dly_q[k-1];
        if (!warm_done_c) warm_q <= warm_q + WW'(1);
      end
      s0_q <= s0_c;
      v1_q <= s0_q;
      busy <= s0_c | s0_q;
      if (s0_q) acc_q <= acc_c;
      fir_valid <= v1_q;
      fir_last  <= v1_q && (frame_q == FW'(FRAME - 1));
      if (v1_q) begin
        fir_d   <= sat_c;
        frame_q <= frame_q + FW'(1);
      end
    end
  end

endmodule

// File: doc/fir_stream_framer.md
FIR_STREAM_FRAMER -- requirements
Module: fir_stream_framer

Interface
REQ-001 The block SHALL have parameter TAPS, default 32, meaning the number of filter taps (range 2..64).
REQ-002 The block SHALL have parameter DW, default 16, meaning the signed input and output sample width in Q(DW-8).8 format.
REQ-003 The block SHALL have parameter CW, default 20, meaning the signed coefficient width in Q(CW-16).16 format.
REQ-004 The block SHALL have parameter FRAME, default 16, meaning the number of outputs per frame for the downstream FFT (power of two, 2..1024).
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-006 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port data_valid, input, 1 bit: data holds a sample this cycle.
REQ-008 The block SHALL have port data, input, DW bits: signed input sample.
REQ-009 The block SHALL have port flush, input, 1 bit: clear the delay line, warm-up state, frame counter and in-flight results.
REQ-010 The block SHALL have port coef_we, input, 1 bit: coefficient write strobe.
REQ-011 The block SHALL have port coef_addr, input, 6 bits: coefficient index.
REQ-012 The block SHALL have port coef_wdata, input, CW bits: signed coefficient value.
REQ-013 The block SHALL have port fir_valid, output, 1 bit: fir_d holds a filter output.
REQ-014 The block SHALL have port fir_d, output, DW bits: signed filter output.
REQ-015 The block SHALL have port fir_last, output, 1 bit: marks the last output of a frame; it is only high when fir_valid is high.
REQ-016 The block SHALL have port busy, output, 1 bit: high while a result is in flight.

Function
REQ-017 Each accepted sample (data_valid=1, flush=0) SHALL shift into a TAPS-deep delay line, with x[0] being the newest sample.
REQ-018 The filter SHALL compute y = sum over k=0..TAPS-1 of c[k]*x[k], exactly, in an accumulator of DW+CW+clog2(TAPS) bits.
REQ-019 The output SHALL be rounded half-up: add 2^15, then arithmetic-shift right by 16.
REQ-020 After rounding, the output SHALL saturate to [-2^(DW-1), 2^(DW-1)-1].
REQ-021 Latency: the output for the sample accepted at edge n SHALL appear on fir_d with fir_valid=1 after edge n+2. The pipeline is a registered MAC stage followed by an output register. The pipeline never stalls.
REQ-022 Warm-up: the first TAPS-1 accepted samples after reset or flush SHALL produce no output. The TAPS-th sample and every sample after it SHALL produce exactly one output each.
REQ-023 Gaps in data_valid SHALL produce gaps in fir_valid at the same 2-cycle offset. While fir_valid=0, fir_d SHALL hold its last value.
REQ-024 A frame counter SHALL count fir_valid outputs modulo FRAME. fir_last SHALL be 1 on outputs FRAME, 2*FRAME, and so on.
REQ-025 coef_we=1 with coef_addr<TAPS SHALL write c[coef_addr] at the clock edge. Writes with coef_addr>=TAPS SHALL be ignored.
REQ-026 If a coefficient write and an accepted sample occur in the same cycle, the MAC for that sample SHALL use the old coefficient value.
REQ-027 flush=1 SHALL, on the edge, zero the delay line, restart warm-up, zero the frame counter and cancel both pipeline stages. fir_valid SHALL be 0 on the following two cycles. Coefficients SHALL be unchanged.
REQ-028 If flush and data_valid are both high, flush SHALL win and the sample is dropped.
REQ-029 busy SHALL be the OR of the two pipeline-stage valid bits.

Reset
REQ-030 While rst=0, the following SHALL hold:
- fir_valid=0, fir_last=0, busy=0, fir_d=0
- delay line = 0, warm-up counter = 0, frame counter = 0
- c[0] = 2^16 (1.0, pass-through) and all other c[k] = 0
REQ-031 Assertion of rst mid-stream SHALL discard all in-flight results immediately, with no partial output after deassertion.
REQ-032 The first sample accepted after rst deassertion SHALL start a fresh warm-up.

Verification
REQ-033 Default coefficients, TAPS=32; feed 32 samples 0x0100, 0x0200, ... -> first fir_valid two cycles after the 32nd sample, with fir_d=0x2000. Each later output equals its input sample.
REQ-034 Load all c[k]=0x01000 (1/16); feed constant 0x0100 -> every output is 0x0200. A write of c[40] is ignored, and its effect matches no write.
REQ-035 All c[k]=0x10000; constant input 0x7FFF -> output 0x7FFF (saturated). Constant input 0x8000 -> output 0x8000.
REQ-036 Only c[0]=0x08000 (0.5), others 0; input 0x0001 -> output 0x0001. Input 0xFFFF -> output 0x0000 (round half-up).
REQ-037 FRAME=16; 48 continuous outputs with random 30% data_valid gaps -> fir_last exactly on outputs 16, 32, 48. Output spacing mirrors input spacing at 2-cycle offset.
REQ-038 Assert flush, with data_valid high, at output 20 -> the next two cycles have no fir_valid. The next 31 samples give no output. The first new output has fir_last=0, and its frame count restarts at 1. Repeating the test with rst instead of flush gives the same, with coefficients back to default.
